// File: rtl/dbus_sram_responder_if.sv
// dbus request/response types and the bus interface shared by the core-side
// initiator (master) and the memory-side responder (slave).
package dbus_pkg;
   typedef struct packed {
      logic        valid;
      logic [63:0] addr;
      logic [2:0]  size;
      logic [7:0]  strobe;
      logic [63:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [63:0] data;
   } dbus_resp_t;
endpackage

// Handshake: the initiator raises dreq.valid and holds dreq stable until the
// cycle in which dresp.data_ok=1; addr_ok and data_ok pulse together for
// exactly one cycle and complete the transfer. strobe==0 is a read.
interface dbus_sram_responder_if;
   import dbus_pkg::*;
   dbus_req_t  dreq;
   dbus_resp_t dresp;

   modport master (output dreq, input dresp);
   modport slave  (input dreq, output dresp);
endinterface

// File: rtl/dbus_sram_responder.sv
// Fixed-latency 64-bit-word SRAM behind the dbus request/response protocol.
// Optional macro DBUS_RESP_RANDOM_STALL_EN adds 0-3 LFSR-driven stall cycles.
module dbus_sram_responder
   import dbus_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter int          LATENCY     = 2,
   parameter logic [63:0] BASE_ADDR   = 64'h8000_0000
) (
   input  logic                  clk,
   input  logic                  reset,
   dbus_sram_responder_if.slave  dbus,
   output logic                  busy,
   output logic [1:0]            dbg_state
);

   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state;
   logic [4:0]  cnt;
   logic [63:0] addr_q;
   logic [7:0]  strobe_q;
   logic [63:0] data_q;
   logic        resp_ok;
   logic [63:0] resp_data;

   logic [63:0] mem [DEPTH_WORDS];

   // In IDLE the live request is looked up so a LATENCY==1 read can answer
   // straight away; otherwise the latched copy is used.
   logic [63:0]   lk_addr;
   logic [7:0]    lk_strobe;
   logic [63:0]   lk_off;
   logic          lk_in_range;
   logic [AW-1:0] lk_idx;
   logic [63:0]   lk_rdata;
   logic [4:0]    load_cnt;
   logic          wr_en;

   always_comb begin
      lk_addr     = (state == IDLE) ? dbus.dreq.addr   : addr_q;
      lk_strobe   = (state == IDLE) ? dbus.dreq.strobe : strobe_q;
      lk_off      = lk_addr - BASE_ADDR;
      lk_in_range = (lk_addr >= BASE_ADDR) && ((lk_off >> 3) < 64'(DEPTH_WORDS));
      lk_idx      = lk_off[AW+2:3];
      lk_rdata    = (lk_in_range && (lk_strobe == 8'h00)) ? mem[lk_idx] : 64'h0;
   end

`ifdef DBUS_RESP_RANDOM_STALL_EN
   logic [7:0] lfsr;

   always_ff @(posedge clk) begin
      if (reset) lfsr <= 8'hA5;
      else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   end

   assign load_cnt = 5'(LATENCY - 1) + {3'b000, lfsr[1:0]};
`else
   assign load_cnt = 5'(LATENCY - 1);
`endif

   // cnt holds the WAIT cycles still to go; zero at acceptance means no WAIT.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         addr_q    <= '0;
         strobe_q  <= '0;
         data_q    <= '0;
         resp_ok   <= 1'b0;
         resp_data <= '0;
      end else begin
         resp_ok   <= 1'b0;
         resp_data <= '0;
         case (state)
            IDLE: begin
               if (dbus.dreq.valid) begin
                  addr_q   <= dbus.dreq.addr;
                  strobe_q <= dbus.dreq.strobe;
                  data_q   <= dbus.dreq.data;
                  if (load_cnt == 5'd0) begin
                     cnt       <= '0;
                     state     <= RESP;
                     resp_ok   <= 1'b1;
                     resp_data <= lk_rdata;
                  end else begin
                     cnt   <= load_cnt;
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (!dbus.dreq.valid) begin
                  cnt   <= '0;
                  state <= IDLE;
               end else if (cnt == 5'd1) begin
                  cnt       <= '0;
                  state     <= RESP;
                  resp_ok   <= 1'b1;
                  resp_data <= lk_rdata;
               end else begin
                  cnt <= cnt - 5'd1;
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // The write lands on the edge that ends RESP, before any new acceptance.
   assign wr_en = !reset && (state == RESP) && lk_in_range && (strobe_q != 8'h00);

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < 8; i++) begin
            if (strobe_q[i]) mem[lk_idx][8*i +: 8] <= data_q[8*i +: 8];
         end
      end
   end

   assign dbus.dresp = '{addr_ok: resp_ok, data_ok: resp_ok, data: resp_data};
   assign busy       = (state != IDLE);
   assign dbg_state  = state;

   logic unused_bits;
   assign unused_bits = ^{dbus.dreq.size, lk_off[2:0], lk_off[63:AW+3]};

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Bench for dbus_sram_responder: a LATENCY=2 and a LATENCY=1 instance checked
// every cycle against a transaction-level schedule and word-memory model.
module tb_dbus_sram_responder;
   import dbus_pkg::*;

   localparam logic [63:0] BASE  = 64'h8000_0000;
   localparam int          DEPTH = 1024;
   localparam int          NCYC  = 4096;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0] rst;
   logic [1:0] busy;
   logic [1:0] st0, st1;

   dbus_sram_responder_if bus0 ();
   dbus_sram_responder_if bus1 ();

   dbus_sram_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2), .BASE_ADDR(BASE)) u_dut0 (
      .clk(clk), .reset(rst[0]), .dbus(bus0.slave), .busy(busy[0]), .dbg_state(st0));

   dbus_sram_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1), .BASE_ADDR(BASE)) u_dut1 (
      .clk(clk), .reset(rst[1]), .dbus(bus1.slave), .busy(busy[1]), .dbg_state(st1));

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   bit run_cmp = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Expected per-cycle outputs, indexed [instance][edges since start].
   logic        exp_busy [2][NCYC];
   logic        exp_ok   [2][NCYC];
   logic [63:0] exp_data [2][NCYC];
   logic [63:0] mm [longint];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic int lat_of(input int d);
      return (d == 0) ? 2 : 1;
   endfunction

   function automatic bit in_range(input logic [63:0] a);
      return (a >= BASE) && (((a - BASE) >> 3) < 64'(DEPTH));
   endfunction

   function automatic longint key_of(input int d, input logic [63:0] a);
      return longint'((a - BASE) >> 3) * 2 + longint'(d);
   endfunction

   function automatic logic [63:0] model_read(input int d, input logic [63:0] a);
      if (!in_range(a)) return 64'h0;
      if (!mm.exists(key_of(d, a))) return 64'h0;
      return mm[key_of(d, a)];
   endfunction

   task automatic drive(input int d, input logic v, input logic [63:0] a,
                        input logic [7:0] s, input logic [63:0] w);
      dbus_req_t r;
      r = '{valid: v, addr: a, size: 3'd3, strobe: s, data: w};
      if (d == 0) bus0.dreq = r;
      else        bus1.dreq = r;
   endtask

   function automatic logic dut_ok(input int d);
      return (d == 0) ? bus0.dresp.data_ok : bus1.dresp.data_ok;
   endfunction

   function automatic logic [63:0] dut_data(input int d);
      return (d == 0) ? bus0.dresp.data : bus1.dresp.data;
   endfunction

   // Called at a negedge; the request is accepted on the next posedge (n).
   // ok_rel is the number of edges from acceptance to the data_ok cycle.
   task automatic do_req(input int d, input logic [63:0] a, input logic [7:0] s,
                         input logic [63:0] w, output logic [63:0] got, output int ok_rel);
      int n, lat;
      logic [63:0] v;
      n   = cyc + 1;
      lat = lat_of(d);
      for (int k = n; k < n + lat; k++) exp_busy[d][k] = 1'b1;
      exp_ok[d][n+lat-1]   = 1'b1;
      exp_data[d][n+lat-1] = (s == 8'h00) ? model_read(d, a) : 64'h0;
      if (s != 8'h00 && in_range(a)) begin
         v = model_read(d, a);
         for (int i = 0; i < 8; i++) if (s[i]) v[8*i +: 8] = w[8*i +: 8];
         mm[key_of(d, a)] = v;
      end
      drive(d, 1'b1, a, s, w);
      got    = 64'h0;
      ok_rel = -1;
      repeat (lat) begin
         @(negedge clk);
         if (dut_ok(d)) begin
            got    = dut_data(d);
            ok_rel = cyc - n;
         end
      end
      drive(d, 1'b0, 64'h0, 8'h00, 64'h0);
      @(negedge clk);
   endtask

   // Write on instance 0 that is abandoned in WAIT, by dropping valid or by reset.
   task automatic do_abort(input logic [63:0] a, input logic [63:0] w, input bit use_reset);
      int n;
      n = cyc + 1;
      exp_busy[0][n] = 1'b1;
      drive(0, 1'b1, a, 8'hFF, w);
      @(negedge clk);
      drive(0, 1'b0, 64'h0, 8'h00, 64'h0);
      if (use_reset) rst[0] = 1'b1;
      @(negedge clk);
      if (use_reset) begin
         check("reset_abort_busy", {63'h0, busy[0]}, 64'h0);
         rst[0] = 1'b0;
      end else begin
         check("drop_abort_busy", {63'h0, busy[0]}, 64'h0);
      end
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (run_cmp && cyc < NCYC) begin
         for (int d = 0; d < 2; d++) begin
            logic [2:0] act_f, exp_f;
            if (d == 0) act_f = {busy[0], bus0.dresp.addr_ok, bus0.dresp.data_ok};
            else        act_f = {busy[1], bus1.dresp.addr_ok, bus1.dresp.data_ok};
            exp_f = {exp_busy[d][cyc], exp_ok[d][cyc], exp_ok[d][cyc]};
            check($sformatf("flags_c%0d_d%0d", cyc, d), {61'h0, act_f}, {61'h0, exp_f});
            check($sformatf("data_c%0d_d%0d", cyc, d), dut_data(d), exp_data[d][cyc]);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got hang, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] got;
      int          rel;
      int          prev_ok;
      for (int d = 0; d < 2; d++)
         for (int k = 0; k < NCYC; k++) begin
            exp_busy[d][k] = 1'b0;
            exp_ok[d][k]   = 1'b0;
            exp_data[d][k] = 64'h0;
         end
      rst = 2'b11;
      drive(0, 1'b0, 64'h0, 8'h00, 64'h0);
      drive(1, 1'b0, 64'h0, 8'h00, 64'h0);
      repeat (3) @(negedge clk);
      check("reset_addr_ok", {63'h0, bus0.dresp.addr_ok}, 64'h0);
      check("reset_data_ok", {63'h0, bus0.dresp.data_ok}, 64'h0);
      check("reset_data", bus0.dresp.data, 64'h0);
      check("reset_busy", {62'h0, busy}, 64'h0);
      check("reset_state", {62'h0, st0}, 64'h0);
      rst = 2'b00;
      run_cmp = 1'b1;
      repeat (10) @(negedge clk);

      // Write then read; data_ok one edge after acceptance is spec cycle N+2.
      do_req(0, 64'h8000_0010, 8'hFF, 64'h1122_3344_5566_7788, got, rel);
      check("wr_latency", 64'(rel), 64'd1);
      do_req(0, 64'h8000_0010, 8'h00, 64'h0, got, rel);
      check("rd_latency", 64'(rel), 64'd1);
      check("rd_after_wr", got, 64'h1122_3344_5566_7788);

      do_req(0, 64'h8000_0010, 8'h0F, 64'hFFFF_FFFF_AABB_CCDD, got, rel);
      do_req(0, 64'h8000_0010, 8'h00, 64'h0, got, rel);
      check("byte_strobe_low", got, 64'h1122_3344_AABB_CCDD);

      do_req(0, 64'h8000_0008, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D, got, rel);
      do_req(0, 64'h8000_0008, 8'h81, 64'h1100_0000_0000_0022, got, rel);
      do_req(0, 64'h8000_0008, 8'h00, 64'h0, got, rel);
      check("byte_strobe_edges", got, 64'h11AD_BEEF_CAFE_F022);

      do_req(0, 64'h8000_0000, 8'hFF, 64'h0F0F_0F0F_F0F0_F0F0, got, rel);
      do_req(0, 64'h8000_1FF8, 8'hFF, 64'h0123_4567_89AB_CDEF, got, rel);

      // Out of range below base, one past the top, and far above (no aliasing).
      do_req(0, 64'h7FFF_FFF8, 8'h00, 64'h0, got, rel);
      check("oor_rd_latency", 64'(rel), 64'd1);
      check("oor_rd_data", got, 64'h0);
      do_req(0, 64'h8000_2000, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, got, rel);
      do_req(0, 64'hFFFF_FFFF_8000_0010, 8'hFF, 64'h5555_5555_5555_5555, got, rel);
      do_req(0, 64'hFFFF_FFFF_8000_0010, 8'h00, 64'h0, got, rel);
      check("wrap_rd_data", got, 64'h0);
      do_req(0, 64'h8000_0000, 8'h00, 64'h0, got, rel);
      check("oor_keep_word0", got, 64'h0F0F_0F0F_F0F0_F0F0);
      do_req(0, 64'h8000_1FF8, 8'h00, 64'h0, got, rel);
      check("oor_keep_last", got, 64'h0123_4567_89AB_CDEF);
      do_req(0, 64'h8000_0010, 8'h00, 64'h0, got, rel);
      check("wrap_keep_word2", got, 64'h1122_3344_AABB_CCDD);

      // Aborted writes must leave the target word alone.
      do_abort(64'h8000_0010, 64'h9999_9999_9999_9999, 1'b0);
      do_req(0, 64'h8000_0010, 8'h00, 64'h0, got, rel);
      check("drop_abort_word", got, 64'h1122_3344_AABB_CCDD);
      do_abort(64'h8000_0010, 64'h7777_7777_7777_7777, 1'b1);
      do_req(0, 64'h8000_0010, 8'h00, 64'h0, got, rel);
      check("reset_abort_word", got, 64'h1122_3344_AABB_CCDD);

      // LATENCY=1 instance: back-to-back stream, a response every second cycle.
      for (int i = 0; i < 4; i++)
         do_req(1, BASE + 64'(i * 8), 8'hFF, 64'hA000_0000_0000_0000 + 64'(i * 3), got, rel);
      prev_ok = -1;
      for (int i = 0; i < 4; i++) begin
         do_req(1, BASE + 64'(i * 8), 8'h00, 64'h0, got, rel);
         check($sformatf("l1_rd_latency_%0d", i), 64'(rel), 64'd0);
         check($sformatf("l1_rd_data_%0d", i), got, 64'hA000_0000_0000_0000 + 64'(i * 3));
         if (prev_ok >= 0) check($sformatf("l1_spacing_%0d", i), 64'(cyc - 1 - prev_ok), 64'd2);
         prev_ok = cyc - 1;
      end

      repeat (4) @(negedge clk);
      run_cmp = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/dbus_sram_responder.md
Name: dbus_sram_responder

Overview:
- Data-bus responder: the memory-side endpoint of the core's dbus request/response protocol.
- Accepts one dbus_req_t at a time, models a fixed-latency SRAM of 64-bit words, and returns dbus_resp_t.
- Used as the simulation data memory behind the core, and as a standalone bench target for core load/store verification.

Parameters:
- DEPTH_WORDS, 1024: number of 64-bit words in the array; power of two.
- LATENCY, 2: cycles from request acceptance to data_ok; legal range 1..15.
- BASE_ADDR, 64'h8000_0000: byte address of word 0.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- dreq  input  dbus_req_t  request: valid, addr[63:0], size, strobe[7:0], data[63:0].
- dresp  output  dbus_resp_t  response: addr_ok, data_ok, data[63:0].
- busy  output  1  high while a request is in flight (state != IDLE).

Behaviour:
- One clock, clk; reset is synchronous and active-high.
- Reset values: dresp.addr_ok=0, dresp.data_ok=0, dresp.data=0, busy=0, state=IDLE, latency counter=0. Array contents are not reset.
- Protocol:
  - The initiator holds dreq stable from valid rise until the cycle in which data_ok=1.
  - addr_ok and data_ok are asserted together for exactly one cycle.
  - strobe==0 means read; strobe!=0 means write.
- State IDLE:
  - On dreq.valid=1, latch addr, strobe and data, load cnt=LATENCY-1, and go to WAIT.
  - If LATENCY==1, go directly to RESP.
- State WAIT:
  - cnt decrements each cycle; at cnt==0 go to RESP.
  - If dreq.valid drops, abort to IDLE: no write, no response.
- State RESP (one cycle):
  - addr_ok=data_ok=1.
  - Read: dresp.data = the full 64-bit word at index (addr-BASE_ADDR)>>3; size has no effect on read data.
  - Write: each byte lane i with strobe[i]=1 is updated from data byte i, committed at the clock edge ending RESP. dresp.data is 0 on writes.
  - Next state is IDLE. A new request is only accepted from IDLE, so the minimum spacing between responses is LATENCY+1 cycles.
- Latency: a request seen valid at edge N produces data_ok during cycle N+LATENCY.
- Out of range (addr<BASE_ADDR or index>=DEPTH_WORDS):
  - Still responds with normal timing.
  - Read data is 64'h0; write is dropped.
- Address wrap: index arithmetic is done in 64 bits before the range check; there is no aliasing.
- Reset mid-operation: returns to IDLE in the next cycle; a pending write is never committed; no data_ok.
- Read-after-write to the same word on back-to-back requests returns the newly written data. The write commits before the next request can be accepted.
- dresp.data is 0 in every cycle other than a read's RESP cycle.

Optional Feature:
- Macro: DBUS_RESP_RANDOM_STALL_EN.
- When defined:
  - An 8-bit LFSR (seed 8'hA5 on reset, polynomial x^8+x^6+x^5+x^4+1) advances every cycle.
  - On acceptance, its two LSBs are added to the latency, giving an extra 0-3 WAIT cycles.
  - All other rules are unchanged.
- When undefined: the latency is exactly LATENCY and no LFSR logic exists.

Test Plan:
- Reset then idle: dreq.valid=0 for 10 cycles -> addr_ok/data_ok/busy stay 0, dresp.data=0.
- Write then read: write addr 8000_0010, strobe FF, data 1122334455667788, accepted at edge N -> data_ok in cycle N+2. The following read of the same addr -> data 1122334455667788.
- Byte strobe: after the above, write strobe 8'h0F with data FFFFFFFF_AABBCCDD -> a read returns 11223344_AABBCCDD.
- Out of range: read at 7FFF_FFF8 -> data_ok after LATENCY, data 0. A write at BASE_ADDR+DEPTH_WORDS*8 leaves all in-range words unchanged.
- Abort and reset: assert a write, drop valid in WAIT -> no data_ok, the target word is unchanged. Repeat with reset pulsed in WAIT -> same result, busy=0 on the next cycle.
- LATENCY=1 build: a back-to-back read stream -> data_ok every second cycle, each with the correct data.
